// File: rtl/ads1675_pkg.sv
// Shared types and constants for the ADS1675 frame packer.
//   state_t    : frame FSM states
//   SYNC_WORD  : upper half of every frame header
//   SEQ_W/CNT_W: frame sequence and overflow counter widths
//   sext24to32 : sign-extend a 24-bit sample into a 32-bit payload word
package ads1675_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_DATA = 2'd2,
      S_TRL  = 2'd3
   } state_t;

   localparam logic [15:0] SYNC_WORD = 16'hA5A5;
   localparam int unsigned SEQ_W     = 16;
   localparam int unsigned CNT_W     = 16;

   function automatic logic [31:0] sext24to32(input logic [23:0] s);
      return {{8{s[23]}}, s};
   endfunction

endpackage

// File: rtl/ads1675_frame_packer_if.sv
// AXI-Stream-style output bus of the frame packer.
//   m_tdata/m_tvalid/m_tlast : word, valid, end-of-frame (master -> slave)
//   m_tready                 : downstream ready (slave -> master)
interface ads1675_frame_packer_if #(
   parameter int unsigned OW = 32
) ();

   logic [OW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tready;
   logic          m_tlast;

   modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
   modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);

endinterface

// File: rtl/ads_sync_fifo.sv
// Single-clock sample FIFO with registered write and fall-through head.
//   aclk, areset     : clock, synchronous active-high reset
//   wr_en, wr_data   : push (caller guarantees !full or a same-cycle rd_en)
//   rd_en, rd_data   : pop, head of queue (valid while !empty)
//   full, empty      : status from pointers with one extra wrap bit
module ads_sync_fifo #(
   parameter int unsigned DW    = 24,
   parameter int unsigned DEPTH = 16
) (
   input  logic          aclk,
   input  logic          areset,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          full,
   output logic          empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;

   // Pointer update; the extra MSB distinguishes full from empty.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // Storage; a write into the slot being popped when full is safe because
   // the head is consumed combinationally in the same cycle.
   always_ff @(posedge aclk) begin
      if (wr_en) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
   end

   assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
   assign empty   = (r_wr_ptr == r_rd_ptr);
   assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/ads1675_frame_packer.sv
// Packs ADS1675 samples into framed 32-bit stream words:
// header {A5A5, seq}, FRAME_LEN sign-extended payload words and, when
// ADS1675_PACK_CHKSUM_EN is defined, an XOR checksum trailer.
//   aclk, areset  : clock, synchronous active-high reset
//   en            : sample-acceptance enable (does not stall draining)
//   data, valid   : 24-bit signed sample and its one-cycle strobe
//   m_axis        : output stream (master modport)
//   overflow_cnt  : saturating count of samples dropped on a full FIFO
//   busy          : frame in progress or samples queued
module ads1675_frame_packer
   import ads1675_pkg::*;
#(
   parameter int unsigned DW         = 24,
   parameter int unsigned OW         = 32,
   parameter int unsigned FRAME_LEN  = 64,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  en,
   input  logic [DW-1:0]         data,
   input  logic                  valid,
   ads1675_frame_packer_if.master m_axis,
   output logic [CNT_W-1:0]      overflow_cnt,
   output logic                  busy
);

   localparam int unsigned BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   state_t           r_state;
   logic [BW-1:0]    r_beat;
   logic [SEQ_W-1:0] r_seq;
   logic [CNT_W-1:0] r_ovf;
`ifdef ADS1675_PACK_CHKSUM_EN
   logic [OW-1:0]    r_chk;
`endif

   logic          w_push_req;
   logic          w_wr_en;
   logic          w_rd_en;
   logic          w_drop;
   logic          w_full;
   logic          w_empty;
   logic [DW-1:0] w_head;
   logic          w_hs;
   logic          w_last_beat;
   logic [OW-1:0] w_tdata;
   logic          w_tvalid;
   logic          w_tlast;

   ads_sync_fifo #(
      .DW    (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .aclk    (aclk),
      .areset  (areset),
      .wr_en   (w_wr_en),
      .wr_data (data),
      .rd_en   (w_rd_en),
      .rd_data (w_head),
      .full    (w_full),
      .empty   (w_empty)
   );

   // Push accepted when there is room now or the head leaves this cycle.
   assign w_push_req  = valid && en;
   assign w_hs        = w_tvalid && m_axis.m_tready;
   assign w_rd_en     = (r_state == S_DATA) && w_hs;
   assign w_wr_en     = w_push_req && (!w_full || w_rd_en);
   assign w_drop      = w_push_req && w_full && !w_rd_en;
   assign w_last_beat = (r_beat == BW'(FRAME_LEN - 1));

   // Output word decode from registered state; no input-to-output path.
   always_comb begin
      w_tvalid = 1'b0;
      w_tdata  = '0;
      w_tlast  = 1'b0;
      case (r_state)
         S_HDR: begin
            w_tvalid = 1'b1;
            w_tdata  = OW'({SYNC_WORD, r_seq});
         end
         S_DATA: begin
            w_tvalid = !w_empty;
            w_tdata  = OW'(sext24to32(24'(w_head)));
`ifdef ADS1675_PACK_CHKSUM_EN
            w_tlast  = 1'b0;
`else
            w_tlast  = w_last_beat;
`endif
         end
`ifdef ADS1675_PACK_CHKSUM_EN
         S_TRL: begin
            w_tvalid = 1'b1;
            w_tdata  = r_chk;
            w_tlast  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Frame FSM with beat, sequence, checksum and overflow registers.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state <= S_IDLE;
         r_beat  <= '0;
         r_seq   <= '0;
         r_ovf   <= '0;
`ifdef ADS1675_PACK_CHKSUM_EN
         r_chk   <= '0;
`endif
      end else begin
         if (w_drop && (r_ovf != {CNT_W{1'b1}})) r_ovf <= r_ovf + CNT_W'(1);
         case (r_state)
            S_IDLE: begin
               // A push this cycle starts the header without waiting for
               // the FIFO write to land.
               if (!w_empty || w_wr_en) begin
                  r_state <= S_HDR;
`ifdef ADS1675_PACK_CHKSUM_EN
                  r_chk   <= '0;
`endif
               end
            end
            S_HDR: begin
               if (w_hs) begin
                  r_state <= S_DATA;
                  r_beat  <= '0;
`ifdef ADS1675_PACK_CHKSUM_EN
                  r_chk   <= r_chk ^ w_tdata;
`endif
               end
            end
            S_DATA: begin
               if (w_hs) begin
                  r_beat <= r_beat + BW'(1);
`ifdef ADS1675_PACK_CHKSUM_EN
                  r_chk  <= r_chk ^ w_tdata;
                  if (w_last_beat) r_state <= S_TRL;
`else
                  if (w_last_beat) begin
                     r_state <= S_IDLE;
                     r_seq   <= r_seq + SEQ_W'(1);
                  end
`endif
               end
            end
`ifdef ADS1675_PACK_CHKSUM_EN
            S_TRL: begin
               if (w_hs) begin
                  r_state <= S_IDLE;
                  r_seq   <= r_seq + SEQ_W'(1);
               end
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign m_axis.m_tdata  = w_tdata;
   assign m_axis.m_tvalid = w_tvalid;
   assign m_axis.m_tlast  = w_tlast;
   assign overflow_cnt    = r_ovf;
   assign busy            = (r_state != S_IDLE) || !w_empty;

endmodule
